cla_nibble_sequencer: RTL and testbench
=======================================

# cla_nibble_sequencer

Sequencer that sits around the registered 4-bit carry-lookahead adder stage. It accepts wide operands through a valid/ready handshake and drives them into the adder one nibble at a time. Each nibble's carry-out is fed back as the next nibble's carry-in, so wide additions reuse the single 4-bit adder. Once all nibbles are done, it presents the packed sum and final carry through a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of 4 and ≥ 4. N = WIDTH/4 nibbles.
- LAT, 3, cycles from presenting x/y/cin at the adder inputs to the matching z/cout being valid at the adder outputs; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- res  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- in_x  in  WIDTH  operand A.
- in_y  in  WIDTH  operand B.
- in_cin  in  1  carry-in to nibble 0.
- ax  out  4  adder x input.
- ay  out  4  adder y input.
- acin  out  1  adder carry-in.
- az  in  4  adder sum output.
- acout  in  1  adder carry-out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  packed sum.
- out_cout  out  1  carry-out of the top nibble.
- busy  out  1  high in ISSUE or DONE.

## Operation
- **States:** IDLE, ISSUE, DONE.
- **Counters:** nibble counter k (0..N-1) and window counter w (0..LAT).
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready: latch in_x, in_y, in_cin; set k = 0, w = 0; go to ISSUE.
- **ISSUE**
  - ax = latched x[4k+3:4k] and ay = latched y[4k+3:4k], held constant for the whole window.
  - acin = latched in_cin when k = 0; otherwise the captured acout of nibble k-1.
  - w increments each cycle.
  - On the edge where w == LAT: capture az into sum[4k+3:4k] and acout into the carry register.
  - If k < N-1 on that edge: increment k, set w = 0.
  - If k == N-1 on that edge: go to DONE.
- **DONE**
  - out_valid = 1; out_sum and out_cout hold the captured values and are stable.
  - On out_valid && out_ready: go to IDLE.
- **Outputs outside their active state**
  - in_ready = 0 in ISSUE and DONE; in_valid is ignored there.
  - out_valid = 0 outside DONE.
  - ax/ay/acin are 0 in IDLE and DONE.
- **Arithmetic:** out_sum = (in_x + in_y + in_cin) mod 2^WIDTH. out_cout = bit WIDTH of the full sum. No saturation.
- **Reset behaviour:**
  - Reset asserted in any state abandons the operation: next state IDLE, no out_valid is produced, partial sum is discarded.
  - res has priority over every handshake in the same cycle.

## Timing
- **Reset values:** in_ready = 1 (IDLE); out_valid = 0, out_sum = 0, out_cout = 0, ax = 0, ay = 0, acin = 0, busy = 0.
- **Nibble window:** each nibble occupies LAT+1 cycles.
- **Latency:** with acceptance on the edge ending cycle t, nibble 0 is driven in cycles t+1..t+1+LAT. out_valid first rises in cycle t+1+N·(LAT+1). For WIDTH=16, LAT=3 that is cycle t+17.
- **Back-to-back:** result handshake in cycle u gives in_ready = 1 in cycle u+1. There is no same-cycle bypass from output handshake to input acceptance. Minimum issue interval is N·(LAT+1)+2 cycles.
- **Backpressure:** out_ready low holds DONE indefinitely, with outputs frozen.

## Test plan
- **Reset values:** assert res for 2 cycles with random inputs → every output at its reset value, in_ready = 1; release → still IDLE.
- **No-carry add:** 0x1234 + 0x4321, cin 0, out_ready 1 → out_valid in cycle t+17; out_sum 0x5555, out_cout 0; acin = 0 in all four windows.
- **Full carry ripple:** 0xFFFF + 0x0001, cin 0 → out_sum 0x0000, out_cout 1; acin observed as 0, 1, 1, 1 across windows; ax nibbles F, F, F, F.
- **Backpressure:** 0x8000 + 0x8000 with out_ready low for 5 cycles → out_sum 0x0000, out_cout 1 held stable; in_ready 0 throughout; a pulse on in_valid is ignored; out_ready high → IDLE next cycle.
- **Reset mid-operation:** assert res while k = 2 → IDLE next cycle, no out_valid pulse; a following 0x00FF + 0x0001 gives 0x0100, cout 0.
- **Back-to-back with carry-in:** 0x0000 + 0x0000, cin 1, then 0xFFFF + 0xFFFF, cin 1, with out_ready tied high → results 0x0001/0, then 0xFFFF/1; second acceptance exactly one cycle after the first result handshake.

Source files
------------

// File: rtl/cla_nibble_sequencer.sv
// Drives a wide addition through a single registered 4-bit CLA stage, one nibble
// per window, chaining each nibble's carry-out into the next nibble's carry-in.
module cla_nibble_sequencer #(
  parameter int WIDTH = 16,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  output logic [3:0]       ax,
  output logic [3:0]       ay,
  output logic             acin,
  input  logic [3:0]       az,
  input  logic             acout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(LAT + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [WW-1:0] W_LAST = WW'(LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WW-1:0]    w_q, w_d;
  logic [WIDTH-1:0] x_q, y_q, sum_q;
  logic             cin_q, carry_q;
  logic             accept, capture;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      k_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      w_q     <= w_d;
    end
  end

  // Operand and result storage is never reset; outputs are gated by state instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q   <= in_x;
      y_q   <= in_y;
      cin_q <= in_cin;
    end
    if (capture) begin
      sum_q[4*k_q +: 4] <= az;
      carry_q           <= acout;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    w_d       = w_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    ax        = 4'h0;
    ay        = 4'h0;
    acin      = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
          k_d     = '0;
          w_d     = '0;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        ax   = x_q[4*k_q +: 4];
        ay   = y_q[4*k_q +: 4];
        // Nibble 0 takes the external carry; later nibbles take the chained carry.
        acin = (k_q == '0) ? cin_q : carry_q;
        w_d  = w_q + 1'b1;
        if (w_q == W_LAST) begin
          capture = 1'b1;
          if (k_q == K_LAST) begin
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
            w_d = '0;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_sum  = (state_q == DONE) ? sum_q : '0;
  assign out_cout = (state_q == DONE) ? carry_q : 1'b0;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: a LAT-deep registered 4-bit adder model on the
// adder port, directed scenarios and randomized additions checked against x+y+cin.
module tb_cla_nibble_sequencer;

  localparam int WIDTH   = 16;
  localparam int LAT     = 3;
  localparam int N       = WIDTH / 4;
  localparam int WIN     = LAT + 1;
  localparam int LATENCY = N * WIN + 1;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             res;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x, in_y;
  logic             in_cin;
  logic [3:0]       ax, ay, az;
  logic             acin, acout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  cla_nibble_sequencer #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .res(res),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_cin(in_cin),
    .ax(ax), .ay(ay), .acin(acin), .az(az), .acout(acout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered adder with LAT cycles from inputs to outputs.
  logic [4:0] apipe [LAT];
  initial for (int i = 0; i < LAT; i++) apipe[i] = 5'd0;
  always @(posedge clk) begin
    apipe[0] <= {1'b0, ax} + {1'b0, ay} + {4'b0, acin};
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign az    = apipe[LAT-1][3:0];
  assign acout = apipe[LAT-1][4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand set in the current (IDLE) cycle and follows the run until
  // out_valid, logging ax/acin at each window start and whether they held steady.
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, output int lat,
                        output logic [4*N-1:0] axl, output logic [N-1:0] acl,
                        output logic stable);
    in_x = x; in_y = y; in_cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_x = WIDTH'($urandom); in_y = WIDTH'($urandom); in_cin = 1'($urandom);
    lat = 1; stable = 1'b1; axl = '0; acl = '0;
    while (!out_valid && lat < TIMEOUT) begin
      int j = (lat - 1) / WIN;
      int p = (lat - 1) % WIN;
      if (j < N) begin
        if (p == 0) begin
          axl[4*j +: 4] = ax;
          acl[j]        = acin;
        end else if (ax !== axl[4*j +: 4] || acin !== acl[j]) begin
          stable = 1'b0;
        end
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom); in_x = WIDTH'($urandom); in_y = WIDTH'($urandom);
      in_cin = 1'($urandom); out_ready = 1'($urandom);
      tick();
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_sum !== '0 || out_cout !== 1'b0) begin failures++; $display("FAIL reset_out_sum got=%h/%b want=0000/0", out_sum, out_cout); end
    checks++; if (ax !== 4'h0 || ay !== 4'h0 || acin !== 1'b0) begin failures++; $display("FAIL reset_adder_in got=%h/%h/%b want=0/0/0", ax, ay, acin); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    res = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset_release got=ready%b busy%b want=ready1 busy0", in_ready, busy); end
  endtask

  task automatic test_no_carry();
    int lat; logic [4*N-1:0] axl; logic [N-1:0] acl; logic st;
    out_ready = 1'b1;
    run_op(16'h1234, 16'h4321, 1'b0, lat, axl, acl, st);
    checks++; if (lat !== LATENCY) begin failures++; $display("FAIL nocarry_latency got=%0d want=%0d", lat, LATENCY); end
    checks++; if (out_sum !== 16'h5555 || out_cout !== 1'b0) begin failures++; $display("FAIL nocarry_sum got=%h/%b want=5555/0", out_sum, out_cout); end
    checks++; if (acl !== 4'b0000 || st !== 1'b1) begin failures++; $display("FAIL nocarry_acin got=%b stable=%b want=0000 stable=1", acl, st); end
    checks++; if (axl !== 16'h1234) begin failures++; $display("FAIL nocarry_ax got=%h want=1234", axl); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL nocarry_return got=ready%b valid%b want=ready1 valid0", in_ready, out_valid); end
  endtask

  task automatic test_ripple();
    int lat; logic [4*N-1:0] axl; logic [N-1:0] acl; logic st;
    out_ready = 1'b1;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, axl, acl, st);
    checks++; if (out_sum !== 16'h0000 || out_cout !== 1'b1) begin failures++; $display("FAIL ripple_sum got=%h/%b want=0000/1", out_sum, out_cout); end
    checks++; if (acl !== 4'b1110 || st !== 1'b1) begin failures++; $display("FAIL ripple_acin got=%b stable=%b want=1110 stable=1", acl, st); end
    checks++; if (axl !== 16'hFFFF) begin failures++; $display("FAIL ripple_ax got=%h want=ffff", axl); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat; logic [4*N-1:0] axl; logic [N-1:0] acl; logic st;
    out_ready = 1'b0;
    run_op(16'h8000, 16'h8000, 1'b0, lat, axl, acl, st);
    checks++; if (lat !== LATENCY) begin failures++; $display("FAIL bp_latency got=%0d want=%0d", lat, LATENCY); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0000 || out_cout !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=v%b %h/%b r%b want=v1 0000/1 r0", i, out_valid, out_sum, out_cout, in_ready);
      end
      in_valid = (i == 2); in_x = 16'h1111; in_y = 16'h2222;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b1 || out_sum !== 16'h0000) begin failures++; $display("FAIL bp_still_done got=v%b %h want=v1 0000", out_valid, out_sum); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got=r%b v%b b%b want=r1 v0 b0", in_ready, out_valid, busy); end
  endtask

  task automatic test_reset_mid();
    int lat; int seen; logic [4*N-1:0] axl; logic [N-1:0] acl; logic st;
    out_ready = 1'b1;
    in_x = 16'hABCD; in_y = 16'h1357; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2 * WIN; i++) tick();
    checks++; if (ax !== 4'hB || busy !== 1'b1) begin failures++; $display("FAIL rstmid_nibble2 got=ax%h b%b want=axb b1", ax, busy); end
    res = 1'b1;
    tick();
    res = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=r%b b%b v%b want=r1 b0 v0", in_ready, busy, out_valid); end
    seen = 0;
    for (int i = 0; i < 3 * LATENCY; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_no_valid got=%0d want=0", seen); end
    run_op(16'h00FF, 16'h0001, 1'b0, lat, axl, acl, st);
    checks++; if (out_sum !== 16'h0100 || out_cout !== 1'b0 || lat !== LATENCY) begin failures++; $display("FAIL rstmid_next got=%h/%b lat=%0d want=0100/0 lat=%0d", out_sum, out_cout, lat, LATENCY); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat; logic [4*N-1:0] axl; logic [N-1:0] acl; logic st;
    out_ready = 1'b1;
    run_op(16'h0000, 16'h0000, 1'b1, lat, axl, acl, st);
    checks++; if (out_sum !== 16'h0001 || out_cout !== 1'b0) begin failures++; $display("FAIL b2b_first got=%h/%b want=0001/0", out_sum, out_cout); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_no_bypass got=%b want=0", in_ready); end
    in_valid = 1'b1; in_x = 16'hFFFF; in_y = 16'hFFFF; in_cin = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_next got=%b want=1", in_ready); end
    run_op(16'hFFFF, 16'hFFFF, 1'b1, lat, axl, acl, st);
    checks++; if (out_sum !== 16'hFFFF || out_cout !== 1'b1 || lat !== LATENCY) begin failures++; $display("FAIL b2b_second got=%h/%b lat=%0d want=ffff/1 lat=%0d", out_sum, out_cout, lat, LATENCY); end
    tick();
  endtask

  task automatic test_random();
    int lat; logic [4*N-1:0] axl; logic [N-1:0] acl; logic st;
    logic [WIDTH-1:0] x, y; logic c; logic [WIDTH:0] exp; int hold;
    for (int n = 0; n < 25; n++) begin
      x = WIDTH'($urandom); y = WIDTH'($urandom); c = 1'($urandom);
      exp = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
      hold = $urandom_range(0, 3);
      out_ready = (hold == 0);
      run_op(x, y, c, lat, axl, acl, st);
      checks++;
      if (lat !== LATENCY || out_sum !== exp[WIDTH-1:0] || out_cout !== exp[WIDTH] || axl !== x || st !== 1'b1) begin
        failures++;
        $display("FAIL random_%0d x=%h y=%h c=%b got=%h/%b lat=%0d want=%h/%b lat=%0d", n, x, y, c, out_sum, out_cout, lat, exp[WIDTH-1:0], exp[WIDTH], LATENCY);
      end
      for (int i = 0; i < hold; i++) tick();
      out_ready = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL random_return_%0d got=%b want=1", n, in_ready); end
    end
  endtask

  initial begin
    res = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_cin = 1'b0; out_ready = 1'b1;
    #1;
    test_reset();
    test_no_carry();
    test_ripple();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
